// File: rtl/mips_pkg.sv
// mips_pkg: shared MDU op encodings and FSM state type
package mips_pkg;
  typedef enum logic [1:0] {MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11} mdu_op_t;
  typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, FIX = 2'b10} mdu_state_t;
endpackage

// File: rtl/mdu.sv
// mdu: iterative 32-bit MULT/MULTU/DIV/DIVU unit owning HI/LO; clk, async active-low reset, start/op/a/b launch, hi_we/lo_we/wd MTHI/MTLO, hi/lo/busy/done outputs
module mdu
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);
  mdu_state_t  state;
  mdu_op_t     op_q;
  logic [4:0]  cnt;
  logic        sa, sb, is_div, neg;
  logic [31:0] ma, mb, abs_a, abs_b, qv, rv, a_orig;
  logic [32:0] sum, r, diff;
  logic [63:0] acc, acc_n, mres, res;
  // acc holds {partial/remainder, multiplier/dividend bits}; the low half is consumed one bit per step
  always_comb begin
    abs_a  = (op[0] & a[31]) ? -a : a;
    abs_b  = (op[0] & b[31]) ? -b : b;
    is_div = (op_q == DIVU) || (op_q == DIV);
    sum    = {1'b0, acc[63:32]} + {1'b0, acc[0] ? mb : 32'd0};
    r      = {acc[63:32], acc[31]};
    diff   = r - {1'b0, mb};
    acc_n  = is_div ? (diff[32] ? {r[31:0], acc[30:0], 1'b0} : {diff[31:0], acc[30:0], 1'b1})
                    : {sum, acc[31:1]};
    neg    = sa ^ sb;
    mres   = neg ? -acc : acc;
    qv     = neg ? -acc[31:0] : acc[31:0];
    rv     = sa ? -acc[63:32] : acc[63:32];
    a_orig = sa ? -ma : ma;
    res    = !is_div ? mres : (mb == 32'd0 ? {a_orig, 32'hFFFFFFFF} : {rv, qv});
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      op_q  <= MULTU;
      cnt   <= 5'd0;
      sa    <= 1'b0;
      sb    <= 1'b0;
      ma    <= 32'd0;
      mb    <= 32'd0;
      acc   <= 64'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start) begin
            op_q  <= mdu_op_t'(op);
            sa    <= op[0] & a[31];
            sb    <= op[0] & b[31];
            ma    <= abs_a;
            mb    <= abs_b;
            acc   <= {32'd0, abs_a};
            cnt   <= 5'd0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_n;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          hi    <= res[63:32];
          lo    <= res[31:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
